packetizer_rr_arbiter: RTL and testbench
========================================

# packetizer_rr_arbiter

Round-robin arbiter and output staging register that shares one packetizer input port among NUM_REQ requesters. Each requester presents a payload word plus destination router address and VC; the block selects one per accepted transfer, registers it, and drives the packetizer's data_in/valid_in/dst_in/vc_in with ready back-pressure from the packetizer's ready_out. It sits between client translators and the packetizer on the NoC ingress path.

## Interface
- NUM_REQ, 4, number of requesters (2..16, need not be a power of two)
- WIDTH_IN, 12, payload width per requester (matches packetizer WIDTH_IN)
- ADDRESS_WIDTH, 4, destination router address width
- VC_ADDRESS_WIDTH, 1, virtual-channel id width
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- req_data_in  input  NUM_REQ*WIDTH_IN  payload, requester i at [i*WIDTH_IN +: WIDTH_IN]
- req_dst_in  input  NUM_REQ*ADDRESS_WIDTH  destination, same slicing
- req_vc_in  input  NUM_REQ*VC_ADDRESS_WIDTH  VC id, same slicing
- req_valid_in  input  NUM_REQ  request valid per requester
- req_ready_out  output  NUM_REQ  one-hot accept strobe per requester
- data_out  output  WIDTH_IN  registered payload to packetizer
- dst_out  output  ADDRESS_WIDTH  registered destination
- vc_out  output  VC_ADDRESS_WIDTH  registered VC
- valid_out  output  1  staging register holds a word
- ready_in  input  1  packetizer can accept this cycle

## Operation
- States: EMPTY (staging register empty, valid_out=0), FULL (valid_out=1).
- load_ok = (state==EMPTY) | ready_in.
- Arbitration: scan req_valid_in from ptr upward, wrapping at NUM_REQ; first valid index is winner. No valid → no winner.
- req_ready_out[winner] = load_ok & any_valid; all other bits 0. At most one bit set per cycle.
- Transfer from requester i occurs when req_valid_in[i] & req_ready_out[i]; that edge loads data/dst/vc slices of i into the staging register, state → FULL.
- On FULL & ready_in & no winner: state → EMPTY; data/dst/vc hold last value.
- On FULL & ready_in & winner: new word loaded, state stays FULL (back-to-back, no bubble).
- On FULL & !ready_in: register and state hold; all req_ready_out = 0.
- ptr update: on each transfer from index k, ptr ← k+1, or 0 if k==NUM_REQ-1. Unchanged otherwise. ptr width = $clog2(NUM_REQ), min 1.
- Requesters must not make req_valid_in depend on req_ready_out; once asserted, valid and fields stay stable until accepted.
- Fairness: any continuously valid requester is accepted within NUM_REQ transfers.

## Timing
- Reset values: valid_out=0, data_out=0, dst_out=0, vc_out=0, ptr=0, state=EMPTY; req_ready_out=0 during rst.
- Request-to-output latency: 1 cycle (accepted at edge N, valid_out high after edge N).
- Throughput: 1 word/cycle while ready_in stays high.
- req_ready_out is combinational from req_valid_in, ptr, state, ready_in; no other combinational input-to-output paths.
- Reset mid-operation: staged word discarded, no partial transfer, ptr back to 0.

## Structure
- Shared package packetizer_arb_pkg: state enum (ARB_EMPTY, ARB_FULL) and a function next_ptr(k, NUM_REQ) for wrap.
- One sub-module rr_pick: combinational round-robin picker (valid vector + ptr → one-hot grant, index, any_valid), reused by other NoC-port arbiters.
- Top holds staging register, FSM, ptr, field slicing/mux.

## Test plan
- Reset: hold rst 3 cycles with all req_valid_in=4'b1111 → valid_out=0, req_ready_out=0, outputs 0; first cycle after rst grants requester 0.
- All four valid, ready_in=1 constantly, distinct payloads 12'h0A0..12'h0A3 → grants 0,1,2,3,0 on consecutive cycles, data_out follows one cycle later, no bubbles.
- Only requester 2 valid, ptr=3 → wrap scan grants 2; next ptr=3; then requester 3 valid → grants 3, ptr=0.
- FULL with ready_in=0 for 5 cycles, requesters 1 and 3 valid → data_out stable, req_ready_out=0 throughout; on ready_in=1 grant goes to 1 (or 3 per ptr) same cycle as drain.
- Single request, ready_in=1, then no requests → valid_out high exactly 1 cycle, state back to EMPTY, data_out holds last value.
- Assert rst while FULL and ready_in=0 → next cycle valid_out=0, ptr=0, no requester sees an accept.

Source files
------------

// File: rtl/packetizer_arb_pkg.sv
// Shared types and helpers for the packetizer ingress arbiters: staging-register
// state encoding, round-robin pointer wrap and pointer width.
package packetizer_arb_pkg;

    typedef enum logic [0:0] {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    // Pointer width for a given requester count, never narrower than one bit.
    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Priority moves to the requester just after the one last served.
    function automatic int unsigned next_ptr(input int unsigned k, input int unsigned num_req);
        return (k == num_req - 1) ? 32'd0 : k + 32'd1;
    endfunction

endpackage

// File: rtl/packetizer_rr_arbiter_if.sv
// Requester-side and packetizer-side signals of the ingress arbiter in one bundle,
// plus the debug view of the staging FSM and the round-robin pointer.
interface packetizer_rr_arbiter_if
    import packetizer_arb_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int WIDTH_IN         = 12,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1
);
    localparam int PTR_W = ptr_width(NUM_REQ);

    // Handshake: a requester transfer happens on the rising edge where both
    // req_valid_in[i] and req_ready_out[i] are high; valid must not depend on
    // ready and payload stays stable until accepted. The packetizer side takes
    // the staged word on each edge where valid_out and ready_in are both high.
    logic [NUM_REQ*WIDTH_IN-1:0]         req_data_in;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0]    req_dst_in;
    logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0] req_vc_in;
    logic [NUM_REQ-1:0]                  req_valid_in;
    logic [NUM_REQ-1:0]                  req_ready_out;

    logic [WIDTH_IN-1:0]                 data_out;
    logic [ADDRESS_WIDTH-1:0]            dst_out;
    logic [VC_ADDRESS_WIDTH-1:0]         vc_out;
    logic                                valid_out;
    logic                                ready_in;

    logic [0:0]                          state_dbg;
    logic [PTR_W-1:0]                    ptr_dbg;

    modport master (
        output req_data_in, req_dst_in, req_vc_in, req_valid_in, ready_in,
        input  req_ready_out, data_out, dst_out, vc_out, valid_out,
        input  state_dbg, ptr_dbg
    );

    modport slave (
        input  req_data_in, req_dst_in, req_vc_in, req_valid_in, ready_in,
        output req_ready_out, data_out, dst_out, vc_out, valid_out,
        output state_dbg, ptr_dbg
    );

endinterface

// File: rtl/packetizer_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after ptr,
// wrapping at N. Works for any N, not only powers of two.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any_valid
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int off = 0; off < N; off++) begin
            pos = int'(ptr) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && valid[pos]) begin
                found      = 1'b1;
                idx        = PTR_W'(pos);
                grant[pos] = 1'b1;
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/packetizer_rr_arbiter.sv
// Round-robin arbiter plus one-word staging register in front of the packetizer
// input port; refills in the same cycle it drains so throughput stays 1 word/cycle.
module packetizer_rr_arbiter
    import packetizer_arb_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int WIDTH_IN         = 12,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1
) (
    input logic                    clk,
    input logic                    rst,
    packetizer_rr_arbiter_if.slave bus
);

    localparam int         PTR_W    = ptr_width(NUM_REQ);
    localparam logic [0:0] ST_EMPTY = ARB_EMPTY;
    localparam logic [0:0] ST_FULL  = ARB_FULL;

    logic [0:0]                  state_q;
    logic [PTR_W-1:0]            ptr_q;
    logic [WIDTH_IN-1:0]         data_q;
    logic [ADDRESS_WIDTH-1:0]    dst_q;
    logic [VC_ADDRESS_WIDTH-1:0] vc_q;

    logic [NUM_REQ-1:0]          grant;
    logic [PTR_W-1:0]            win_idx;
    logic                        any_valid;
    logic                        load_ok;
    logic                        take;

    logic [WIDTH_IN-1:0]         sel_data;
    logic [ADDRESS_WIDTH-1:0]    sel_dst;
    logic [VC_ADDRESS_WIDTH-1:0] sel_vc;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid     (bus.req_valid_in),
        .ptr       (ptr_q),
        .grant     (grant),
        .idx       (win_idx),
        .any_valid (any_valid)
    );

    // The register can take a new word when empty, or when the current one
    // leaves on this same edge.
    assign load_ok = (state_q == ST_EMPTY) | bus.ready_in;
    assign take    = load_ok & any_valid & ~rst;

    assign bus.req_ready_out = take ? grant : '0;

    always_comb begin
        sel_data = '0;
        sel_dst  = '0;
        sel_vc   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(win_idx) == i) begin
                sel_data = bus.req_data_in[i*WIDTH_IN +: WIDTH_IN];
                sel_dst  = bus.req_dst_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_vc   = bus.req_vc_in[i*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            dst_q   <= '0;
            vc_q    <= '0;
        end else if (take) begin
            state_q <= ST_FULL;
            ptr_q   <= PTR_W'(next_ptr(32'(win_idx), NUM_REQ));
            data_q  <= sel_data;
            dst_q   <= sel_dst;
            vc_q    <= sel_vc;
        end else if ((state_q == ST_FULL) && bus.ready_in) begin
            // Drained with nothing to refill; fields keep the last word.
            state_q <= ST_EMPTY;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.dst_out   = dst_q;
    assign bus.vc_out    = vc_q;
    assign bus.valid_out = (state_q == ST_FULL);
    assign bus.state_dbg = state_q;
    assign bus.ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_packetizer_rr_arbiter.sv
// Directed bench for packetizer_rr_arbiter: reset, rotation, wrap, back-pressure,
// drain to empty and reset while full, all with hand-computed expectations.
module tb_packetizer_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH_IN = 12;
    localparam int ADDRESS_WIDTH = 4;
    localparam int VC_ADDRESS_WIDTH = 1;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    packetizer_rr_arbiter_if #(
        .NUM_REQ          (NUM_REQ),
        .WIDTH_IN         (WIDTH_IN),
        .ADDRESS_WIDTH    (ADDRESS_WIDTH),
        .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH)
    ) bus ();

    packetizer_rr_arbiter #(
        .NUM_REQ          (NUM_REQ),
        .WIDTH_IN         (WIDTH_IN),
        .ADDRESS_WIDTH    (ADDRESS_WIDTH),
        .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requester i presents data base+i, dst i+4, vc = bit 0 of i.
    task automatic set_req(input logic [NUM_REQ-1:0] v, input logic [WIDTH_IN-1:0] base);
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_data_in[i*WIDTH_IN +: WIDTH_IN] = base + WIDTH_IN'(i);
            bus.req_dst_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = ADDRESS_WIDTH'(i + 4);
            bus.req_vc_in[i] = 1'(i);
        end
        bus.req_valid_in = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_word(input string tag, input logic [11:0] d, input logic [3:0] dst,
                            input logic vc, input logic [1:0] ptr);
        chk({tag, ".valid"}, 32'(bus.valid_out), 32'd1);
        chk({tag, ".data"},  32'(bus.data_out),  32'(d));
        chk({tag, ".dst"},   32'(bus.dst_out),   32'(dst));
        chk({tag, ".vc"},    32'(bus.vc_out),    32'(vc));
        chk({tag, ".ptr"},   32'(bus.ptr_dbg),   32'(ptr));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.ready_in = 1'b1;
        set_req(4'b1111, 12'h0A0);

        // reset held 3 cycles with all requesters valid
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst.ready", 32'(bus.req_ready_out), 32'h0);
            chk("rst.valid", 32'(bus.valid_out), 32'h0);
            chk("rst.data",  32'(bus.data_out), 32'h0);
            chk("rst.dst",   32'(bus.dst_out), 32'h0);
            chk("rst.vc",    32'(bus.vc_out), 32'h0);
            chk("rst.ptr",   32'(bus.ptr_dbg), 32'h0);
            chk("rst.state", 32'(bus.state_dbg), 32'h0);
        end
        rst = 1'b0;
        #1;

        // rotation 0,1,2,3,0 with no bubbles
        for (int k = 0; k < 5; k++) begin
            chk("rot.grant", 32'(bus.req_ready_out), 32'(1 << (k % 4)));
            step();
            chk_word("rot", 12'h0A0 + 12'(k % 4), 4'(k % 4 + 4), 1'(k % 4), 2'((k + 1) % 4));
        end

        // bring ptr to 3 via requester 2, then wrap scan back to 2, then 3
        set_req(4'b0100, 12'h0A0);
        #1;
        chk("wrap.a.grant", 32'(bus.req_ready_out), 32'b0100);
        step();
        chk_word("wrap.a", 12'h0A2, 4'h6, 1'b0, 2'd3);
        set_req(4'b0100, 12'h0B0);
        #1;
        chk("wrap.b.grant", 32'(bus.req_ready_out), 32'b0100);
        step();
        chk_word("wrap.b", 12'h0B2, 4'h6, 1'b0, 2'd3);
        set_req(4'b1000, 12'h0B0);
        #1;
        chk("wrap.c.grant", 32'(bus.req_ready_out), 32'b1000);
        step();
        chk_word("wrap.c", 12'h0B3, 4'h7, 1'b1, 2'd0);

        // back-pressure for 5 cycles with requesters 1 and 3 waiting
        bus.ready_in = 1'b0;
        set_req(4'b1010, 12'h0C0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp.grant", 32'(bus.req_ready_out), 32'h0);
            step();
            chk_word("bp.hold", 12'h0B3, 4'h7, 1'b1, 2'd0);
        end
        bus.ready_in = 1'b1;
        #1;
        chk("bp.release.grant", 32'(bus.req_ready_out), 32'b0010);
        step();
        chk_word("bp.release", 12'h0C1, 4'h5, 1'b1, 2'd2);

        // drain to empty, single request, drain again
        set_req(4'b0000, 12'h0C0);
        #1;
        chk("drain.grant", 32'(bus.req_ready_out), 32'h0);
        step();
        chk("drain.valid", 32'(bus.valid_out), 32'h0);
        chk("drain.state", 32'(bus.state_dbg), 32'h0);
        chk("drain.data",  32'(bus.data_out), 32'h0C1);
        set_req(4'b0001, 12'h0D0);
        #1;
        chk("single.grant", 32'(bus.req_ready_out), 32'b0001);
        step();
        chk_word("single", 12'h0D0, 4'h4, 1'b0, 2'd1);
        set_req(4'b0000, 12'h0D0);
        step();
        chk("single.end.valid", 32'(bus.valid_out), 32'h0);
        chk("single.end.state", 32'(bus.state_dbg), 32'h0);
        chk("single.end.data",  32'(bus.data_out), 32'h0D0);

        // reset while full and stalled
        set_req(4'b0100, 12'h0E0);
        #1;
        chk("rfull.load.grant", 32'(bus.req_ready_out), 32'b0100);
        step();
        chk_word("rfull.load", 12'h0E2, 4'h6, 1'b0, 2'd3);
        bus.ready_in = 1'b0;
        set_req(4'b1111, 12'h0E0);
        #1;
        chk("rfull.stall.grant", 32'(bus.req_ready_out), 32'h0);
        rst = 1'b1;
        #1;
        chk("rfull.rst.grant", 32'(bus.req_ready_out), 32'h0);
        step();
        chk("rfull.rst.ready", 32'(bus.req_ready_out), 32'h0);
        chk("rfull.valid", 32'(bus.valid_out), 32'h0);
        chk("rfull.ptr",   32'(bus.ptr_dbg), 32'h0);
        chk("rfull.data",  32'(bus.data_out), 32'h0);
        chk("rfull.state", 32'(bus.state_dbg), 32'h0);
        rst = 1'b0;
        #1;
        chk("post.rst.grant", 32'(bus.req_ready_out), 32'b0001);
        step();
        chk_word("post.rst", 12'h0E0, 4'h4, 1'b0, 2'd1);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
